// File: rtl/kgp_risc_multicycle_core.sv
// Multi-cycle KGP-RISC core: one shared instruction/data memory behind a req/ack port,
// a FETCH/DECODE/EXEC/MEM/WB sequencer, and halt / single-step control at instruction boundaries.
module kgp_risc_multicycle_core #(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata,
   input  logic              i_mem_ack,
   input  logic              i_halt_req,
   output logic              o_halted,
   output logic              o_retire,
   output logic              o_illegal,
   output logic [31:0]       o_pc_out
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t              r_state;
   logic [31:0]         r_pc, r_ir, r_a, r_b, r_res;
   logic                r_c;
   logic [31:0]         r_rf [32];
   logic                r_mem_req, r_mem_we, r_halted, r_retire, r_illegal;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_shamt, w_dst;
   logic [31:0] w_sext, w_pc4, w_jaddr, w_baddr, w_ea, w_alu, w_target, w_npc;
   logic        w_cout, w_illegal, w_is_mem, w_is_sw, w_is_ctrl, w_wr_c, w_done;
   logic        w_unused;

   assign w_op     = r_ir[31:26];
   assign w_rs     = r_ir[25:21];
   assign w_rt     = r_ir[20:16];
   assign w_shamt  = r_ir[15:11];
   assign w_funct  = r_ir[10:5];
   assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_pc4    = r_pc + 32'd4;
   assign w_jaddr  = {w_pc4[31:28], r_ir[25:0], 2'b00};
   assign w_baddr  = w_pc4 + {w_sext[29:0], 2'b00};
   assign w_ea     = r_a + w_sext;
   assign w_unused = ^{w_ea[31:ADDR_W+2], w_ea[1:0]};

   assign w_illegal = ((w_op == 6'd0) && (w_funct > 6'd6)) || (w_op > 6'd12);
   assign w_is_mem  = (w_op == 6'd3) || (w_op == 6'd4);
   assign w_is_sw   = (w_op == 6'd4);
   assign w_is_ctrl = (w_op >= 6'd5) || w_illegal;
   assign w_wr_c    = ((w_op == 6'd0) && (w_funct == 6'd0)) || (w_op == 6'd1);
   assign w_dst     = (w_op == 6'd3) ? w_rt : w_rs;

   always_comb begin
      w_alu  = '0;
      w_cout = 1'b0;
      case (w_op)
         6'd0: begin
            case (w_funct)
               6'd0:    {w_cout, w_alu} = {1'b0, r_a} + {1'b0, r_b};
               6'd1:    w_alu = -r_b;
               6'd2:    w_alu = r_a & r_b;
               6'd3:    w_alu = r_a ^ r_b;
               6'd4:    w_alu = r_a << w_shamt;
               6'd5:    w_alu = r_a >> w_shamt;
               6'd6:    w_alu = $signed(r_a) >>> w_shamt;
               default: ;
            endcase
         end
         6'd1:    {w_cout, w_alu} = {1'b0, r_a} + {1'b0, w_sext};
         6'd2:    w_alu = -w_sext;
         default: ;
      endcase
   end

   // Control-transfer target; illegal ops and untaken branches fall through to pc4.
   always_comb begin
      w_target = w_pc4;
      case (w_op)
         6'd5, 6'd6: w_target = w_jaddr;
         6'd7:       w_target = r_a;
         6'd8:       if (r_a == 32'd0) w_target = w_baddr;
         6'd9:       if (r_a != 32'd0) w_target = w_baddr;
         6'd10:      if (r_a[31])      w_target = w_baddr;
         6'd11:      if (r_c)          w_target = w_baddr;
         6'd12:      if (!r_c)         w_target = w_baddr;
         default:    ;
      endcase
   end

   assign w_done = ((r_state == S_EXEC) && w_is_ctrl) ||
                   ((r_state == S_MEM) && i_mem_ack && w_is_sw) ||
                   (r_state == S_WB);
   assign w_npc  = (r_state == S_EXEC) ? w_target : w_pc4;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_c         <= 1'b0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_halted    <= 1'b0;
         r_retire    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_retire  <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!r_mem_req) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc[ADDR_W+1:2];
               end else if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_ir      <= i_mem_rdata;
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a     <= r_rf[w_rs];
               r_b     <= r_rf[w_rt];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_res     <= w_alu;
               r_illegal <= w_illegal;
               if (w_wr_c) r_c <= w_cout;
               if (w_op == 6'd6) r_rf[31] <= w_pc4;
               if (w_is_mem) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_is_sw;
                  r_mem_addr  <= w_ea[ADDR_W+1:2];
                  r_mem_wdata <= r_b;
                  r_state     <= S_MEM;
               end else if (!w_is_ctrl) begin
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_res     <= i_mem_rdata;
                  if (!w_is_sw) r_state <= S_WB;
               end
            end
            S_WB: r_rf[w_dst] <= r_res;
            S_HALT: begin
               if (!i_halt_req) begin
                  r_halted   <= 1'b0;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc[ADDR_W+1:2];
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
         // Instruction boundary: overrides the per-state updates above.
         if (w_done) begin
            r_pc     <= w_npc;
            r_retire <= 1'b1;
            if (i_halt_req) begin
               r_state   <= S_HALT;
               r_halted  <= 1'b1;
               r_mem_req <= 1'b0;
            end else begin
               r_state    <= S_FETCH;
               r_mem_req  <= 1'b1;
               r_mem_we   <= 1'b0;
               r_mem_addr <= w_npc[ADDR_W+1:2];
            end
         end
      end
   end

   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_halted    = r_halted;
   assign o_retire    = r_retire;
   assign o_illegal   = r_illegal;
   assign o_pc_out    = r_pc;

endmodule

// File: tb/tb_kgp_risc_multicycle_core.sv
// Bench for kgp_risc_multicycle_core: behavioural memory with programmable ack latency,
// scoreboard queues of expected retires (PC, illegal) and expected stores.
module tb_kgp_risc_multicycle_core;

   localparam int ADDR_W = 10;

   typedef struct { logic [31:0] pc; bit ill; bit hlt; } ret_t;
   typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } st_t;

   logic              clk, rst;
   logic              o_mem_req, o_mem_we, o_halted, o_retire, o_illegal;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata, o_pc_out;
   logic [31:0]       rdata;
   logic              ack;
   bit                halt_tb, want_halt;
   logic              halt_req;

   assign halt_req = halt_tb | want_halt;

   kgp_risc_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(rdata), .i_mem_ack(ack),
      .i_halt_req(halt_req), .o_halted(o_halted), .o_retire(o_retire),
      .o_illegal(o_illegal), .o_pc_out(o_pc_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   ret_t              q_ret[$];
   st_t               q_st[$];
   int                ret_cyc[$];
   int                n_tot, n_bad, cyc, lat, wcnt, t_req0;
   bit                have_p, p_we;
   logic [ADDR_W-1:0] p_addr;
   logic [31:0]       p_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] enc_r(int fn, int rs, int rt, int sh);
      return {6'd0, 5'(rs), 5'(rt), 5'(sh), 6'(fn), 5'd0};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(int op, int tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   task automatic exp_ret(input logic [31:0] pc, input bit ill, input bit hlt);
      ret_t e;
      e.pc = pc; e.ill = ill; e.hlt = hlt;
      q_ret.push_back(e);
   endtask
   task automatic exp_st(input int addr, input logic [31:0] d);
      st_t s;
      s.addr = ADDR_W'(addr); s.data = d;
      q_st.push_back(s);
   endtask

   // One clock: sample at the falling edge, score retires, run the memory model.
   task automatic tick();
      ret_t e;
      st_t  s;
      @(negedge clk);
      cyc++;
      if (rst) begin
         ack = 1'b0; wcnt = 0; have_p = 1'b0;
         return;
      end
      if (t_req0 < 0 && o_mem_req) t_req0 = cyc;
      if (o_retire) begin
         chk("ret_expected", 32'(q_ret.size() > 0), 32'd1);
         if (q_ret.size() > 0) begin
            e = q_ret.pop_front();
            chk("ret_pc", o_pc_out, e.pc);
            chk("ret_illegal", 32'(o_illegal), 32'(e.ill));
            if (e.hlt) want_halt = 1'b1;
            ret_cyc.push_back(cyc);
         end
      end else if (o_illegal) begin
         chk("illegal_without_retire", 32'(o_illegal), 32'd0);
      end
      // ack high at this edge means the transfer completed on the preceding rising edge
      if (ack) begin
         if (p_we) begin
            chk("st_expected", 32'(q_st.size() > 0), 32'd1);
            if (q_st.size() > 0) begin
               s = q_st.pop_front();
               chk("st_addr", 32'(p_addr), 32'(s.addr));
               chk("st_data", p_wdata, s.data);
            end
            mem[p_addr] = p_wdata;
         end
         wcnt = 0; have_p = 1'b0;
      end
      if (have_p) begin
         chk("req_held", 32'(o_mem_req), 32'd1);
         chk("addr_stable", 32'(o_mem_addr), 32'(p_addr));
         chk("we_stable", 32'(o_mem_we), 32'(p_we));
         chk("wdata_stable", o_mem_wdata, p_wdata);
      end
      if (!o_mem_req) begin
         ack = 1'b0; wcnt = 0; have_p = 1'b0;
      end else begin
         p_addr = o_mem_addr; p_we = o_mem_we; p_wdata = o_mem_wdata; have_p = 1'b1;
         if (wcnt >= lat) begin
            ack = 1'b1; rdata = mem[o_mem_addr];
         end else begin
            ack = 1'b0; wcnt++;
         end
      end
   endtask

   task automatic begin_test(input int lat_v, input bit halt_v);
      rst = 1'b1; halt_tb = halt_v; want_halt = 1'b0; lat = lat_v; t_req0 = -1;
      q_ret.delete(); q_st.delete(); ret_cyc.delete();
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'hFFFF_FFFF;
      tick();
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(q_ret.size() == 0 && q_st.size() == 0 && o_halted) && n < 400) begin
         tick(); n++;
      end
      chk(tag, 32'(n < 400), 32'd1);
      chk({tag, "_noreq"}, 32'(o_mem_req), 32'd0);
   endtask

   initial begin
      n_tot = 0; n_bad = 0; cyc = 0; ack = 1'b0; rdata = '0; have_p = 1'b0;
      p_we = 1'b0; p_addr = '0; p_wdata = '0; wcnt = 0;

      // addi/add, store of $1, bncy taken on C=0; plus reset values and CPI
      begin_test(0, 1'b0);
      chk("rst_req", 32'(o_mem_req), 32'd0);
      chk("rst_we", 32'(o_mem_we), 32'd0);
      chk("rst_addr", 32'(o_mem_addr), 32'd0);
      chk("rst_wdata", o_mem_wdata, 32'd0);
      chk("rst_halted", 32'(o_halted), 32'd0);
      chk("rst_retire", 32'(o_retire), 32'd0);
      chk("rst_illegal", 32'(o_illegal), 32'd0);
      chk("rst_pc", o_pc_out, 32'd0);
      mem[0] = enc_i(1, 1, 0, 5);
      mem[1] = enc_r(0, 1, 1, 0);
      mem[2] = enc_i(4, 0, 1, 'h100);
      mem[3] = enc_i(12, 0, 0, 1);
      mem[5] = enc_j(5, 5);
      exp_ret(4, 0, 0); exp_ret(8, 0, 0); exp_ret(12, 0, 0); exp_st('h40, 32'd10);
      exp_ret(20, 0, 0); exp_ret(20, 0, 1); exp_ret(20, 0, 0);
      rst = 1'b0;
      tick();
      chk("req_first_edge", 32'(o_mem_req), 32'd1);
      wait_done("t1_done");
      if (ret_cyc.size() >= 2) begin
         chk("cpi_first", 32'(ret_cyc[0] - t_req0), 32'd4);
         chk("cpi_second", 32'(ret_cyc[1] - t_req0), 32'd8);
      end

      // carry from addi, bcy taken
      begin_test(0, 1'b0);
      mem[0] = enc_i(2, 2, 0, 1);
      mem[1] = enc_i(1, 2, 0, 1);
      mem[2] = enc_i(11, 0, 0, 2);
      mem[5] = enc_i(4, 0, 2, 'h104);
      mem[6] = enc_j(5, 6);
      exp_ret(4, 0, 0); exp_ret(8, 0, 0); exp_ret(20, 0, 0); exp_ret(24, 0, 0);
      exp_st('h41, 32'd0); exp_ret(24, 0, 1); exp_ret(24, 0, 0);
      rst = 1'b0;
      wait_done("t2_done");

      // sw/lw round trip with 3 wait cycles per transfer
      begin_test(3, 1'b0);
      mem[0] = enc_i(1, 3, 0, 'h8765);
      mem[1] = enc_i(4, 0, 3, 4);
      mem[2] = enc_i(3, 0, 4, 7);
      mem[3] = enc_i(4, 0, 4, 'h108);
      mem[4] = enc_j(5, 4);
      exp_ret(4, 0, 0); exp_ret(8, 0, 0); exp_st(1, 32'hFFFF_8765);
      exp_ret(12, 0, 0); exp_ret(16, 0, 0); exp_st('h42, 32'hFFFF_8765);
      exp_ret(16, 0, 1); exp_ret(16, 0, 0);
      rst = 1'b0;
      wait_done("t3_done");

      // bl / br round trip through $31
      begin_test(0, 1'b0);
      mem[0]     = enc_j(6, 'h40);
      mem['h40]  = enc_i(4, 0, 31, 'h180);
      mem['h41]  = enc_i(7, 31, 0, 0);
      mem[1]     = enc_j(5, 1);
      exp_ret(32'h100, 0, 0); exp_ret(32'h104, 0, 0); exp_st('h60, 32'd4);
      exp_ret(4, 0, 0); exp_ret(4, 0, 1); exp_ret(4, 0, 0);
      rst = 1'b0;
      wait_done("t4_done");

      // shifts, logic ops, comp, bltz/bnz/bz
      begin_test(0, 1'b0);
      mem[0]  = enc_i(2, 7, 0, 16);
      mem[1]  = enc_r(6, 7, 0, 4);
      mem[2]  = enc_r(5, 7, 0, 28);
      mem[3]  = enc_r(4, 7, 0, 8);
      mem[4]  = enc_i(1, 9, 0, 'hFF);
      mem[5]  = enc_r(3, 7, 9, 0);
      mem[6]  = enc_r(2, 7, 9, 0);
      mem[7]  = enc_r(1, 7, 7, 0);
      mem[8]  = enc_i(4, 0, 7, 'h100);
      mem[9]  = enc_i(10, 7, 0, 1);
      mem[11] = enc_i(9, 10, 0, 5);
      mem[12] = enc_i(8, 10, 0, 1);
      mem[14] = enc_j(5, 14);
      for (int p = 4; p <= 36; p += 4) exp_ret(32'(p), 0, 0);
      exp_st('h40, 32'hFFFF_FF01);
      exp_ret(44, 0, 0); exp_ret(48, 0, 0); exp_ret(56, 0, 0);
      exp_ret(56, 0, 1); exp_ret(56, 0, 0);
      rst = 1'b0;
      wait_done("t5_done");

      // illegal op 0x3F and R-type funct 7: pulse, PC+4, no side effects
      begin_test(0, 1'b0);
      mem[0] = enc_i(1, 6, 0, 9);
      mem[1] = 32'hFC00_0000;
      mem[2] = enc_r(7, 6, 0, 0);
      mem[3] = enc_i(4, 0, 6, 'h100);
      mem[4] = enc_j(5, 4);
      exp_ret(4, 0, 0); exp_ret(8, 1, 0); exp_ret(12, 1, 0); exp_ret(16, 0, 0);
      exp_st('h40, 32'd9); exp_ret(16, 0, 1); exp_ret(16, 0, 0);
      rst = 1'b0;
      wait_done("t6_done");

      // halt from reset, then two single steps
      begin_test(0, 1'b1);
      mem[0] = enc_i(1, 1, 0, 1);
      mem[1] = enc_i(1, 1, 0, 1);
      mem[2] = enc_i(4, 0, 1, 'h100);
      mem[3] = enc_j(5, 3);
      exp_ret(4, 0, 0); exp_ret(8, 0, 0); exp_ret(12, 0, 0); exp_st('h40, 32'd2);
      rst = 1'b0;
      for (int n = 0; n < 40 && !o_halted; n++) tick();
      chk("halt_first", 32'(o_halted), 32'd1);
      chk("halt_one_retire", 32'(q_ret.size()), 32'd2);
      repeat (5) tick();
      chk("halt_parked_noreq", 32'(o_mem_req), 32'd0);
      chk("halt_parked_retires", 32'(q_ret.size()), 32'd2);
      halt_tb = 1'b0; tick(); halt_tb = 1'b1;
      repeat (12) tick();
      chk("step1_retires", 32'(q_ret.size()), 32'd1);
      chk("step1_halted", 32'(o_halted), 32'd1);
      halt_tb = 1'b0; tick(); halt_tb = 1'b1;
      repeat (12) tick();
      chk("step2_retires", 32'(q_ret.size()), 32'd0);
      chk("step2_store", 32'(q_st.size()), 32'd0);
      chk("step2_halted", 32'(o_halted), 32'd1);

      // reset during a MEM wait
      begin_test(5, 1'b0);
      mem[0] = enc_i(1, 1, 0, 3);
      mem[1] = enc_i(4, 0, 1, 'h100);
      exp_ret(4, 0, 0);
      rst = 1'b0;
      for (int n = 0; n < 60 && !(o_mem_req && o_mem_we); n++) tick();
      chk("mem_wait_seen", 32'(o_mem_req && o_mem_we), 32'd1);
      tick();
      chk("mem_wait_pc", o_pc_out, 32'd4);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_req", 32'(o_mem_req), 32'd0);
      chk("rst_async_pc", o_pc_out, 32'd0);
      chk("rst_async_addr", 32'(o_mem_addr), 32'd0);
      chk("rst_async_retires", 32'(q_ret.size()), 32'd0);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
